// File: rtl/ti_pkg.sv
// Shared definitions for the threshold-implementation share decoder.
package ti_pkg;

    localparam int NSHARES_DEF = 3;
    localparam int W_DEF       = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } ti_state_e;

endpackage : ti_pkg

// File: rtl/ti_share_acc.sv
// Share accumulator: tracks the expected share index, folds accepted shares
// together and flags out-of-order shares with a one-cycle error pulse.
module ti_share_acc
    import ti_pkg::*;
#(
    parameter int NSHARES = NSHARES_DEF,
    parameter int W       = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         accept,
    input  logic [W-1:0] share,
    input  logic [1:0]   idx,
    output logic         last,
    output logic [W-1:0] result,
    output logic         err
);

    localparam logic [1:0] LAST_IDX = 2'(NSHARES - 1);

    logic [1:0]   cnt_r;
    logic [W-1:0] acc_r;
    logic         err_r;
    logic         match_s;

    assign match_s = (idx == cnt_r);
    assign last    = accept & match_s & (cnt_r == LAST_IDX);
    // Only consumed by the output register on the final share.
    assign result  = acc_r ^ share;
    assign err     = err_r;

    // Counter/accumulator update; a wrong index discards the partial set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 2'd0;
            acc_r <= '0;
            err_r <= 1'b0;
        end else if (accept) begin
            if (!match_s) begin
                cnt_r <= 2'd0;
                acc_r <= '0;
                err_r <= 1'b1;
            end else if (cnt_r == LAST_IDX) begin
                // Set complete: scrub the partial XOR so nothing lingers.
                cnt_r <= 2'd0;
                acc_r <= '0;
                err_r <= 1'b0;
            end else if (cnt_r == 2'd0) begin
                // First share loads directly, never mixed with stale data.
                cnt_r <= cnt_r + 2'd1;
                acc_r <= share;
                err_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + 2'd1;
                acc_r <= acc_r ^ share;
                err_r <= 1'b0;
            end
        end else begin
            err_r <= 1'b0;
        end
    end

endmodule : ti_share_acc

// File: rtl/ti_share_decoder.sv
// Recombines NSHARES Boolean shares of a masked nibble into the unmasked
// value; the output is registered and forced to zero whenever not valid.
module ti_share_decoder
    import ti_pkg::*;
#(
    parameter int NSHARES = NSHARES_DEF,
    parameter int W       = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_share,
    input  logic [1:0]   in_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         err
);

    ti_state_e    state_r, state_nx_s;
    logic         in_ready_r, in_ready_nx_s;
    logic         out_valid_r, out_valid_nx_s;
    logic [W-1:0] out_data_r, out_data_nx_s;
    logic         accept_s;
    logic         last_s;
    logic [W-1:0] result_s;
    logic         err_s;

    assign accept_s = in_valid & in_ready_r;

    ti_share_acc #(
        .NSHARES (NSHARES),
        .W       (W)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .accept (accept_s),
        .share  (in_share),
        .idx    (in_idx),
        .last   (last_s),
        .result (result_s),
        .err    (err_s)
    );

    // Next-state and next-output logic for the COLLECT/HOLD controller.
    always_comb begin
        state_nx_s     = state_r;
        in_ready_nx_s  = in_ready_r;
        out_valid_nx_s = out_valid_r;
        out_data_nx_s  = out_data_r;
        case (state_r)
            COLLECT: begin
                in_ready_nx_s  = 1'b1;
                out_valid_nx_s = 1'b0;
                out_data_nx_s  = '0;
                if (last_s) begin
                    state_nx_s     = HOLD;
                    in_ready_nx_s  = 1'b0;
                    out_valid_nx_s = 1'b1;
                    out_data_nx_s  = result_s;
                end else begin
                    state_nx_s = COLLECT;
                end
            end
            HOLD: begin
                in_ready_nx_s = 1'b0;
                if (out_valid_r && out_ready) begin
                    state_nx_s     = COLLECT;
                    in_ready_nx_s  = 1'b1;
                    out_valid_nx_s = 1'b0;
                    out_data_nx_s  = '0;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            default: begin
                state_nx_s     = COLLECT;
                in_ready_nx_s  = 1'b0;
                out_valid_nx_s = 1'b0;
                out_data_nx_s  = '0;
            end
        endcase
    end

    // State and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= COLLECT;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_data_r  <= out_data_nx_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign err       = err_s;

endmodule : ti_share_decoder

// File: tb/tb_ti_share_decoder.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a share-set reference model.
module tb_ti_share_decoder;

    localparam int NSHARES = 3;
    localparam int W       = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_share;
    logic [1:0]   in_idx;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         err;

    int checks_r;
    int errors_r;

    // Reference model state, expressed as "shares collected so far".
    logic [W-1:0] m_shares[$];
    logic         m_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_err;

    ti_share_decoder #(.NSHARES(NSHARES), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_share  (in_share),
        .in_idx    (in_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_shares.delete();
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock from the current inputs, clock the DUT,
    // then compare every output just after the edge.
    task automatic step();
        logic         took;
        logic         new_err;
        logic [W-1:0] x;
        took    = in_valid && m_ready;
        new_err = 1'b0;
        if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_ready = 1'b1;
            end
        end else begin
            m_ready = 1'b1;
            if (took) begin
                if (int'(in_idx) == m_shares.size()) begin
                    m_shares.push_back(in_share);
                    if (m_shares.size() == NSHARES) begin
                        x = '0;
                        foreach (m_shares[i]) x = x ^ m_shares[i];
                        m_data  = x;
                        m_valid = 1'b1;
                        m_ready = 1'b0;
                        m_shares.delete();
                    end
                end else begin
                    m_shares.delete();
                    new_err = 1'b1;
                end
            end
        end
        m_err = new_err;
        @(posedge clk);
        #1;
        check_eq("in_ready",  32'(in_ready),  32'(m_ready));
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data",  32'(out_data),  32'(m_data));
        check_eq("err",       32'(err),       32'(m_err));
    endtask

    task automatic drive(input logic v, input logic [W-1:0] s, input logic [1:0] idx, input logic ordy);
        in_valid  = v;
        in_share  = s;
        in_idx    = idx;
        out_ready = ordy;
        step();
    endtask

    // Asynchronous reset pulse applied away from the clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);
        check_eq("rst_err",       32'(err),       32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int results;
        checks_r  = 0;
        errors_r  = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_share  = '0;
        in_idx    = 2'd0;
        out_ready = 1'b0;
        model_reset();
        #2;
        apply_reset();
        drive(1'b0, 4'h0, 2'd0, 1'b0);
        check_eq("ready_after_rst", 32'(in_ready), 32'd1);

        // Back-to-back set, consumer ready.
        drive(1'b1, 4'h5, 2'd0, 1'b1);
        drive(1'b1, 4'hA, 2'd1, 1'b1);
        drive(1'b1, 4'h3, 2'd2, 1'b1);
        check_eq("basic_valid", 32'(out_valid), 32'd1);
        check_eq("basic_data",  32'(out_data),  32'hC);
        drive(1'b0, 4'h0, 2'd0, 1'b1);
        drive(1'b0, 4'h0, 2'd0, 1'b1);

        // Back-pressure: output held, extra inputs ignored.
        drive(1'b1, 4'h5, 2'd0, 1'b0);
        drive(1'b1, 4'hA, 2'd1, 1'b0);
        drive(1'b1, 4'h3, 2'd2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'h9, 2'd0, 1'b0);
            check_eq("hold_data",  32'(out_data), 32'hC);
            check_eq("hold_ready", 32'(in_ready), 32'd0);
        end
        drive(1'b0, 4'h0, 2'd0, 1'b1);
        check_eq("post_hs_ready", 32'(in_ready),  32'd1);
        check_eq("post_hs_data",  32'(out_data),  32'd0);

        // Order violation followed by a clean set.
        drive(1'b1, 4'h8, 2'd1, 1'b1);
        check_eq("order_err", 32'(err), 32'd1);
        drive(1'b0, 4'h0, 2'd0, 1'b1);
        check_eq("err_one_cycle", 32'(err), 32'd0);
        drive(1'b1, 4'h1, 2'd0, 1'b1);
        drive(1'b1, 4'h2, 2'd1, 1'b1);
        drive(1'b1, 4'h4, 2'd2, 1'b1);
        check_eq("recover_data", 32'(out_data), 32'h7);
        drive(1'b0, 4'h0, 2'd0, 1'b1);

        // Reset in the middle of a set leaves no residue.
        drive(1'b1, 4'h9, 2'd0, 1'b1);
        drive(1'b1, 4'h6, 2'd1, 1'b1);
        apply_reset();
        drive(1'b0, 4'h0, 2'd0, 1'b1);
        drive(1'b1, 4'hF, 2'd0, 1'b1);
        drive(1'b1, 4'hF, 2'd1, 1'b1);
        drive(1'b1, 4'h6, 2'd2, 1'b1);
        check_eq("post_rst_data", 32'(out_data), 32'h6);
        drive(1'b0, 4'h0, 2'd0, 1'b1);

        // Continuous stream: eight results in 32 cycles.
        results = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 2'(m_shares.size()), 1'b1);
            if (out_valid) results++;
        end
        check_eq("stream_count", 32'(results), 32'd8);
        drive(1'b0, 4'h0, 2'd0, 1'b1);

        // Random traffic with occasional bad indices, stalls and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] idx;
            if ($urandom_range(0, 9) == 0) idx = 2'($urandom_range(0, 3));
            else                          idx = 2'(m_shares.size());
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
            end
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  idx, 1'($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule : tb_ti_share_decoder

// File: doc/ti_share_decoder.md
TI_SHARE_DECODER -- requirements
Module: ti_share_decoder

Interface
REQ-001 Parameter NSHARES, default 3, number of Boolean shares per masked nibble.
REQ-002 Parameter W, default 4, share/data width in bits (S-box nibble).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  share word present on in_share/in_idx.
REQ-006 in_ready  output  1  decoder accepts a share this cycle.
REQ-007 in_share  input  W  one Boolean share of the masked S-box output.
REQ-008 in_idx  input  2  share index, 0..NSHARES-1.
REQ-009 out_valid  output  1  recombined nibble available.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_data  output  W  unmasked nibble, XOR of all NSHARES shares.
REQ-012 err  output  1  one-cycle pulse on share-order violation.

Function
REQ-013 Share accepted only on rising edge with in_valid=1 and in_ready=1.
REQ-014 States: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 COLLECT: share counter cnt, range 0..NSHARES-1, gives expected in_idx.
REQ-016 Accepted share with in_idx==cnt==0: acc <= in_share (no XOR with stale acc).
REQ-017 Accepted share with in_idx==cnt>0: acc <= acc ^ in_share; cnt increments.
REQ-018 Accepted share with in_idx==cnt==NSHARES-1: out_data <= acc ^ in_share, cnt <= 0, state <= HOLD; out_valid high from that edge (latency 1 cycle after last share).
REQ-019 Accepted share with in_idx!=cnt: share discarded, acc <= 0, cnt <= 0, err high for exactly the following cycle, state stays COLLECT.
REQ-020 HOLD: out_data and out_valid stable until out_valid&out_ready; then state <= COLLECT, out_valid <= 0, out_data <= 0.
REQ-021 No same-cycle bypass: in_ready rises the edge after the output handshake; peak throughput one nibble per NSHARES+1 cycles.
REQ-022 out_data SHALL be 0 whenever out_valid=0; acc and partial XORs never reach any output (leakage requirement).
REQ-023 out_data is a register output; no combinational path from in_share to out_data.
REQ-024 in_valid while in_ready=0 is ignored; no state change, no err.
REQ-025 in_valid=0 gaps during COLLECT permitted; cnt and acc held.

Reset
REQ-026 rst_n low: state COLLECT, cnt 0, acc 0, out_data 0, out_valid 0, err 0, in_ready 0.
REQ-027 in_ready registered; goes 1 on first rising edge after rst_n deasserts.
REQ-028 Reset mid-collection or in HOLD discards all partial shares and pending output; no out_valid until a full new share set.

Structure
REQ-029 Package ti_pkg holds NSHARES, W defaults and the state enumeration (COLLECT, HOLD).
REQ-030 One sub-module ti_share_acc: cnt, acc, index check, err generation; top holds FSM and output register.
REQ-031 Estimated size 120-250 RTL lines.

Verification
REQ-032 Shares 0x5(idx0), 0xA(idx1), 0x3(idx2) back-to-back, out_ready=1 -> out_valid one cycle after third share, out_data=0xC, err=0.
REQ-033 Same shares, out_ready=0 for 5 cycles -> out_data=0xC held, in_ready=0, extra in_valid ignored; out_ready=1 -> handshake, in_ready=1 next cycle.
REQ-034 First share with in_idx=1 -> err pulse 1 cycle, no out_valid; then 0x1,0x2,0x4 in order -> out_data=0x7.
REQ-035 Two shares accepted, rst_n pulsed low -> all outputs 0; then 0xF,0xF,0x6 -> out_data=0x6, no residue from old shares.
REQ-036 Continuous valid stream, out_ready=1, 8 nibbles -> 8 correct results, one every 4 cycles; out_data=0 on every cycle out_valid=0.
